// File: rtl/keccak_xif_pkg.sv
// Shared types and sizing constants for the XIF-to-Keccak command sequencer.
package keccak_xif_pkg;

  localparam int N_WORDS     = 50;
  localparam int N_PAIRS     = 25;
  localparam int TIMEOUT_CYC = 64;
  localparam int CNT_W       = 7;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_PERM = 2'd1,
    OP_READ = 2'd2,
    OP_RSVD = 2'd3
  } ctrl_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PERM = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/keccak_xif_ctrl.sv
// Single-outstanding command sequencer: LOAD word pairs, launch the permutation with a
// timeout guard, READ state words, and return exactly one response per accepted command.
module keccak_xif_ctrl
  import keccak_xif_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [5:0]    req_idx_i,
  input  logic [31:0]   req_d0_i,
  input  logic [31:0]   req_d1_i,
  output logic          wr_en_o,
  output logic [5:0]    wr_idx_o,
  output logic [31:0]   wr_d0_o,
  output logic [31:0]   wr_d1_o,
  output logic          start_o,
  input  logic          done_i,
  input  logic [1599:0] state_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_data_o,
  output logic          rsp_err_o,
  output logic          busy_o,
  output logic          loaded_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a response, once valid, keeps data/err stable until it is consumed.

  ctrl_state_e        state_q, state_d;
  logic               ready_q, ready_d;
  logic               wr_en_q, wr_en_d;
  logic [5:0]         wr_idx_q, wr_idx_d;
  logic [31:0]        wr_d0_q, wr_d0_d, wr_d1_q, wr_d1_d;
  logic               start_q, start_d;
  logic [N_PAIRS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rd_word;

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      if (req_idx_i == 6'(w)) rd_word = state_i[32*w +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_d0_d     = wr_d0_q;
    wr_d1_d     = wr_d1_q;
    start_d     = 1'b0;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          cnt_d      = '0;
          case (ctrl_op_e'(req_op_i))
            OP_LOAD: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              if (req_idx_i < 6'(N_PAIRS)) begin
                wr_en_d  = 1'b1;
                wr_idx_d = req_idx_i;
                wr_d0_d  = req_d0_i;
                wr_d1_d  = req_d1_i;
                for (int p = 0; p < N_PAIRS; p++) begin
                  if (req_idx_i == 6'(p)) mask_d[p] = 1'b1;
                end
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            OP_READ: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              if (req_idx_i < 6'(N_WORDS)) rsp_data_d = rd_word;
              else                         rsp_err_d  = 1'b1;
            end
            OP_PERM: begin
              state_d = ST_PERM;
              start_d = 1'b1;
              mask_d  = '0;
            end
            default: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_PERM: begin
        // Counter tracks cycles elapsed since the start pulse went out.
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT: begin
        if (done_i) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_d0_q     <= '0;
      wr_d1_q     <= '0;
      start_q     <= 1'b0;
      mask_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_d0_q     <= wr_d0_d;
      wr_d1_q     <= wr_d1_d;
      start_q     <= start_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_idx_o    = wr_idx_q;
  assign wr_d0_o     = wr_d0_q;
  assign wr_d1_o     = wr_d1_q;
  assign start_o     = start_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign loaded_o    = &mask_q;

endmodule

// File: tb/tb_keccak_xif_ctrl.sv
// Directed bench for keccak_xif_ctrl with a response scoreboard of {err, data}.
module tb_keccak_xif_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [5:0]    req_idx = '0;
  logic [31:0]   req_d0 = '0, req_d1 = '0;
  logic          wr_en;
  logic [5:0]    wr_idx;
  logic [31:0]   wr_d0, wr_d1;
  logic          start;
  logic          done = 1'b0;
  logic [1599:0] state_in = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          busy, loaded;

  logic [32:0]   exp_q[$];
  int            n_total = 0;
  int            n_pass = 0;

  keccak_xif_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_idx_i(req_idx), .req_d0_i(req_d0), .req_d1_i(req_d1),
    .wr_en_o(wr_en), .wr_idx_o(wr_idx), .wr_d0_o(wr_d0), .wr_d1_o(wr_d1),
    .start_o(start), .done_i(done), .state_i(state_in),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .busy_o(busy), .loaded_o(loaded)
  );

  // Clock and reset timing: 10 ns period, inputs change and outputs are sampled 1 ns after posedge.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_total++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Driver: hold a command until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [5:0] idx,
                      input logic [31:0] d0, input logic [31:0] d1);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_idx = idx; req_d0 = d0; req_d1 = d1;
    while (!req_ready && n < 200) begin step(); n++; end
    if (!req_ready) fail_now("req_ready_wait");
    step();
    req_valid = 1'b0;
  endtask

  // Scoreboard consumer: waits for a response, optionally stalls it, compares, consumes.
  task automatic recv(input int hold);
    int n = 0;
    logic [32:0] e;
    while (!rsp_valid && n < 200) begin step(); n++; end
    if (!rsp_valid) begin
      fail_now("rsp_valid_wait");
      return;
    end
    if (exp_q.size() == 0) begin
      fail_now("exp_q_empty");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp", {rsp_err, rsp_data}, e);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      step();
    end
    chk("rsp", {rsp_err, rsp_data}, e);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_cleared", {rsp_valid, rsp_err, rsp_data}, 0);
  endtask

  initial begin
    int n;
    for (int w = 0; w < 50; w++) state_in[32*w +: 32] = $urandom;
    state_in[1599:1568] = 32'hCAFEF00D;

    // Reset held for three cycles.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", req_ready, 0);
      chk("rst_outs", {wr_en, start, rsp_valid, rsp_err, busy, loaded}, 0);
      chk("rst_data", {rsp_data, wr_d0}, 0);
    end
    rst_n = 1'b1;
    step(); step();
    chk("ready_after_rst", req_ready, 1);

    // Single LOAD.
    exp_q.push_back({1'b0, 32'h0});
    send(2'd0, 6'd3, 32'hDEADBEEF, 32'h01234567);
    chk("load_wr", {wr_en, wr_idx, wr_d0, wr_d1}, {1'b1, 6'd3, 32'hDEADBEEF, 32'h01234567});
    chk("load_rsp_valid", rsp_valid, 1);
    step();
    chk("load_wr_onecyc", wr_en, 0);
    recv(0);

    // Fill every pair slot.
    for (int p = 0; p < 25; p++) begin
      exp_q.push_back({1'b0, 32'h0});
      if (p == 24) chk("loaded_before_last", loaded, 0);
      send(2'd0, 6'(p), $urandom, $urandom);
      if (p % 8 == 0) chk("fill_wr_idx", {wr_en, wr_idx}, {1'b1, 6'(p)});
      recv(0);
    end
    chk("loaded_all", loaded, 1);

    // PERM answered by done 24 cycles after start.
    send(2'd1, 6'd0, 32'h0, 32'h0);
    chk("perm_start", {start, loaded, busy}, 3'b101);
    step();
    chk("perm_start_onecyc", start, 0);
    repeat (22) step();
    chk("perm_no_rsp_yet", rsp_valid, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("perm_done_rsp", {rsp_valid, busy}, 2'b11);
    exp_q.push_back({1'b0, 32'h0});
    recv(0);

    // PERM with done never arriving.
    exp_q.push_back({1'b1, 32'h0});
    send(2'd1, 6'd0, 32'h0, 32'h0);
    n = 0;
    while (!rsp_valid && n < 200) begin step(); n++; end
    chk("timeout_latency", n, 64);
    recv(0);
    chk("idle_after_timeout", {busy, req_ready}, 2'b01);

    // Stray done in IDLE is ignored.
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("done_in_idle", {busy, rsp_valid, start}, 0);

    // READ words and error cases.
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    send(2'd2, 6'd49, 32'h0, 32'h0);
    recv(0);
    exp_q.push_back({1'b0, state_in[32*17 +: 32]});
    send(2'd2, 6'd17, 32'h0, 32'h0);
    recv(0);
    exp_q.push_back({1'b1, 32'h0});
    send(2'd2, 6'd50, 32'h0, 32'h0);
    recv(0);
    exp_q.push_back({1'b1, 32'h0});
    send(2'd0, 6'd25, 32'h11111111, 32'h22222222);
    chk("load_oor_no_wr", wr_en, 0);
    recv(0);
    exp_q.push_back({1'b1, 32'h0});
    send(2'd3, 6'd0, 32'h0, 32'h0);
    chk("rsvd_no_wr", {wr_en, start}, 0);
    recv(0);

    // Backpressure on a READ response.
    exp_q.push_back({1'b0, state_in[32*5 +: 32]});
    send(2'd2, 6'd5, 32'h0, 32'h0);
    recv(5);

    // Reset while waiting for done abandons the command.
    send(2'd1, 6'd0, 32'h0, 32'h0);
    repeat ($urandom_range(3, 10)) step();
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_idle", {busy, rsp_valid, start}, 0);
    repeat (70) begin
      step();
      if (rsp_valid) break;
    end
    chk("rst_mid_no_rsp", {rsp_valid, busy, req_ready}, 3'b001);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
